// File: rtl/time_entry_pkg.sv
// Shared types and constants for the MM:SS keypad entry block and its
// serial BCD-to-binary converters.
package time_entry_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    OFFER   = 2'd2
  } state_t;

  localparam int CONV_SHIFTS = 7;

  localparam logic [1:0] CUR_M1 = 2'd3;
  localparam logic [1:0] CUR_M0 = 2'd2;
  localparam logic [1:0] CUR_S1 = 2'd1;
  localparam logic [1:0] CUR_S0 = 2'd0;

  typedef logic [3:0] bcd_digit_t;

  // Reverse double-dabble correction applied after each right shift
  function automatic bcd_digit_t dabble_adj(input bcd_digit_t n);
    return (n >= 4'd8) ? bcd_digit_t'(n - 4'd3) : n;
  endfunction

endpackage

// File: rtl/bcd2_to_bin_seq.sv
// Two-digit serial BCD-to-binary converter (reverse double-dabble):
// one load cycle, then CONV_SHIFTS shift cycles, then a one-cycle done pulse.
module bcd2_to_bin_seq
  import time_entry_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       done
);

  localparam logic [2:0] SHIFTS = 3'(CONV_SHIFTS);

  logic [14:0] sr_q, sr_d, shifted;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shifted = sr_q >> 1;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      sr_d  = {bcd, 7'd0};
      cnt_d = SHIFTS;
    end else if (cnt_q != 3'd0) begin
      sr_d   = {dabble_adj(shifted[14:11]), dabble_adj(shifted[10:7]), shifted[6:0]};
      cnt_d  = cnt_q - 3'd1;
      done_d = (cnt_q == 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bin  = sr_q[6:0];
  assign done = done_q;

endmodule

// File: rtl/time_entry.sv
// Keypad MM:SS entry: validates digits as typed, converts the finished entry
// to binary minutes/seconds and offers it to the timer on a valid/ready load.
module time_entry
  import time_entry_pkg::*;
#(
  parameter int unsigned SEC_TENS_MAX = 5,
  parameter bit          ALLOW_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit_in,
  input  logic        digit_stb,
  input  logic        clear,
  output logic [15:0] entry_bcd,
  output logic [1:0]  cursor,
  output logic        busy,
  output logic        err,
  output logic        load_valid,
  input  logic        load_ready,
  output logic [7:0]  load_min,
  output logic [7:0]  load_sec
);

  localparam bcd_digit_t TENS_LIM = bcd_digit_t'(SEC_TENS_MAX);

  state_t      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [1:0]  cursor_q, cursor_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        load_valid_q, load_valid_d;
  logic [7:0]  load_min_q, load_min_d;
  logic [7:0]  load_sec_q, load_sec_d;

  logic        illegal, conv_start;
  logic        min_done, sec_done;
  logic [6:0]  min_bin, sec_bin;

  assign illegal = (digit_in > 4'd9)
                || ((cursor_q == CUR_S1) && (digit_in > TENS_LIM))
                || (!ALLOW_ZERO && (cursor_q == CUR_S0) && (digit_in == 4'd0)
                    && (entry_q[{CUR_M1, 2'b00} +: 4] == 4'd0)
                    && (entry_q[{CUR_M0, 2'b00} +: 4] == 4'd0)
                    && (entry_q[{CUR_S1, 2'b00} +: 4] == 4'd0));

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    cursor_d     = cursor_q;
    err_d        = 1'b0;
    load_valid_d = load_valid_q;
    load_min_d   = load_min_q;
    load_sec_d   = load_sec_q;
    conv_start   = 1'b0;

    case (state_q)
      ENTRY: begin
        if (digit_stb) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            entry_d[{cursor_q, 2'b00} +: 4] = digit_in;
            if (cursor_q == CUR_S0) begin
              // Converters load from the completed entry on this same edge
              state_d    = CONVERT;
              conv_start = 1'b1;
            end else begin
              cursor_d = cursor_q - 2'd1;
            end
          end
        end
      end
      CONVERT: begin
        if (min_done && sec_done) begin
          load_min_d   = {1'b0, min_bin};
          load_sec_d   = {1'b0, sec_bin};
          load_valid_d = 1'b1;
          state_d      = OFFER;
        end
      end
      OFFER: begin
        if (load_ready) begin
          load_valid_d = 1'b0;
          entry_d      = '0;
          cursor_d     = CUR_M1;
          state_d      = ENTRY;
        end
      end
      default: state_d = ENTRY;
    endcase

    // Clear overrides everything; the last load value stays on the bus
    if (clear) begin
      state_d      = ENTRY;
      entry_d      = '0;
      cursor_d     = CUR_M1;
      load_valid_d = 1'b0;
      err_d        = 1'b0;
      conv_start   = 1'b0;
    end

    busy_d = (state_d != ENTRY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ENTRY;
      entry_q      <= '0;
      cursor_q     <= CUR_M1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      load_valid_q <= 1'b0;
      load_min_q   <= '0;
      load_sec_q   <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      cursor_q     <= cursor_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      load_valid_q <= load_valid_d;
      load_min_q   <= load_min_d;
      load_sec_q   <= load_sec_d;
    end
  end

  bcd2_to_bin_seq u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .abort (clear),
    .bcd   (entry_d[15:8]),
    .bin   (min_bin),
    .done  (min_done)
  );

  bcd2_to_bin_seq u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .abort (clear),
    .bcd   (entry_d[7:0]),
    .bin   (sec_bin),
    .done  (sec_done)
  );

  assign entry_bcd  = entry_q;
  assign cursor     = cursor_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign load_valid = load_valid_q;
  assign load_min   = load_min_q;
  assign load_sec   = load_sec_q;

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry: expected load values are queued as entries
// are keyed in and popped when the DUT raises load_valid.
module tb_time_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_stb = 1'b0;
  logic        digit_stb_z = 1'b0;
  logic        clear = 1'b0;
  logic        load_ready = 1'b0;

  logic [15:0] entry_bcd, entry_bcd_z;
  logic [1:0]  cursor, cursor_z;
  logic        busy, busy_z, err, err_z, load_valid, load_valid_z;
  logic [7:0]  load_min, load_min_z, load_sec, load_sec_z;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  time_entry #(.SEC_TENS_MAX(5), .ALLOW_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_stb(digit_stb),
    .clear(clear), .entry_bcd(entry_bcd), .cursor(cursor), .busy(busy),
    .err(err), .load_valid(load_valid), .load_ready(load_ready),
    .load_min(load_min), .load_sec(load_sec)
  );

  time_entry #(.SEC_TENS_MAX(5), .ALLOW_ZERO(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_stb(digit_stb_z),
    .clear(clear), .entry_bcd(entry_bcd_z), .cursor(cursor_z), .busy(busy_z),
    .err(err_z), .load_valid(load_valid_z), .load_ready(load_ready),
    .load_min(load_min_z), .load_sec(load_sec_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] d);
    digit_in  = d;
    digit_stb = 1'b1;
    tick();
    digit_stb = 1'b0;
  endtask

  task automatic strobe_z(input logic [3:0] d);
    digit_in    = d;
    digit_stb_z = 1'b1;
    tick();
    digit_stb_z = 1'b0;
  endtask

  task automatic wait_valid(input bit use_z);
    int n = 0;
    while (!(use_z ? load_valid_z : load_valid) && n < 40) begin
      tick();
      n++;
    end
    chk("valid_timeout", {31'd0, (use_z ? load_valid_z : load_valid)}, 32'd1);
  endtask

  task automatic pop_check(input bit use_z);
    logic [15:0] e;
    chk("queue_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("load_min", use_z ? load_min_z : load_min, {24'd0, e[15:8]});
      chk("load_sec", use_z ? load_sec_z : load_sec, {24'd0, e[7:0]});
    end
  endtask

  initial begin
    bit seen;
    int held;

    // Reset state
    tick(); tick();
    chk("rst_entry", entry_bcd, 32'h0);
    chk("rst_cursor", cursor, 32'd3);
    chk("rst_busy", busy, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_valid", load_valid, 32'd0);
    chk("rst_min_sec", {load_min, load_sec}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: 12:34 with ready high, exact latency
    load_ready = 1'b1;
    strobe(4'd1); chk("t1_cur2", cursor, 32'd2);
    strobe(4'd2); chk("t1_cur1", cursor, 32'd1);
    strobe(4'd3); chk("t1_cur0", cursor, 32'd0);
    strobe(4'd4); exp_q.push_back({8'd12, 8'd34});
    chk("t1_entry", entry_bcd, 32'h1234);
    chk("t1_busy", busy, 32'd1);
    repeat (7) tick();
    chk("t1_valid_early", load_valid, 32'd0);
    tick();
    chk("t1_valid_cycle9", load_valid, 32'd1);
    pop_check(1'b0);
    tick();
    chk("t1_valid_drop", load_valid, 32'd0);
    chk("t1_entry_clr", entry_bcd, 32'h0);
    chk("t1_cursor_rst", cursor, 32'd3);

    // 2: 99:59 held while ready low
    load_ready = 1'b0;
    strobe(4'd9); strobe(4'd9); strobe(4'd5); strobe(4'd9);
    exp_q.push_back({8'd99, 8'd59});
    wait_valid(1'b0);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (load_valid && load_min == 8'd99 && load_sec == 8'd59 && busy) held++;
      tick();
    end
    chk("t2_held20", held, 32'd20);
    pop_check(1'b0);
    load_ready = 1'b1;
    tick();
    chk("t2_xfer_valid", load_valid, 32'd0);
    chk("t2_xfer_busy", busy, 32'd0);
    tick();
    chk("t2_single_xfer", load_valid, 32'd0);

    // 3: digit validation
    strobe(4'd1); strobe(4'd2);
    strobe(4'd7);
    chk("t3_err_tens", err, 32'd1);
    chk("t3_cur_hold", cursor, 32'd1);
    chk("t3_entry_hold", entry_bcd, 32'h1200);
    tick();
    chk("t3_err_1cyc", err, 32'd0);
    strobe(4'd5);
    chk("t3_tens_ok", cursor, 32'd0);
    chk("t3_no_err", err, 32'd0);
    strobe(4'hA);
    chk("t3_err_hex", err, 32'd1);
    chk("t3_cur0_hold", cursor, 32'd0);
    strobe(4'd8); exp_q.push_back({8'd12, 8'd58});
    wait_valid(1'b0);
    pop_check(1'b0);
    tick();

    // 4: 00:00 rejected when zero not allowed
    strobe_z(4'd0); strobe_z(4'd0); strobe_z(4'd0);
    strobe_z(4'd0);
    chk("t4_err_zero", err_z, 32'd1);
    chk("t4_cur_hold", cursor_z, 32'd0);
    chk("t4_busy", busy_z, 32'd0);
    strobe_z(4'd1); exp_q.push_back({8'd0, 8'd1});
    wait_valid(1'b1);
    pop_check(1'b1);
    tick();

    // 5: clear mid-conversion, clear with strobe
    strobe(4'd3); strobe(4'd0); strobe(4'd4); strobe(4'd5);
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_busy", busy, 32'd0);
    chk("t5_entry", entry_bcd, 32'h0);
    chk("t5_cursor", cursor, 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= load_valid;
      tick();
    end
    chk("t5_no_valid", {31'd0, seen}, 32'd0);
    chk("t5_keep_load", {load_min, load_sec}, {16'd0, 8'd12, 8'd58});
    strobe(4'd6);
    chk("t5_pre_entry", entry_bcd, 32'h6000);
    clear = 1'b1;
    strobe(4'd7);
    clear = 1'b0;
    chk("t5_clr_stb_entry", entry_bcd, 32'h0);
    chk("t5_clr_stb_cur", cursor, 32'd3);
    chk("t5_clr_stb_err", err, 32'd0);

    // 6: asynchronous reset while offering
    load_ready = 1'b0;
    strobe(4'd2); strobe(4'd3); strobe(4'd4); strobe(4'd5);
    exp_q.push_back({8'd23, 8'd45});
    wait_valid(1'b0);
    pop_check(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", load_valid, 32'd0);
    chk("t6_async_load", {load_min, load_sec}, 32'h0);
    chk("t6_async_cursor", cursor, 32'd3);
    chk("t6_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
